// File: rtl/ds18b20_reader_pkg.sv
// Shared definitions for the DS18B20 reader: command bytes, state encodings, CRC8 helper.
package ds18b20_reader_pkg;

    localparam int unsigned CONV_CYCLES_DEF = 750000;
    localparam int unsigned ACK_TIMEOUT_DEF = 8;
    localparam int unsigned WAIT_W          = 20;
    localparam int unsigned ACK_W           = 8;
    localparam int unsigned IDX_W           = 4;
    localparam int unsigned SP_BYTES        = 9;

    localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
    localparam logic [7:0] CMD_CONVERT  = 8'h44;
    localparam logic [7:0] CMD_READ_SP  = 8'hBE;
    localparam logic [7:0] CRC_POLY     = 8'h8C;

    typedef enum logic [3:0] {
        S_IDLE, S_RST1, S_SKIP1, S_CONV, S_WAIT_CONV,
        S_RST2, S_SKIP2, S_READ_CMD, S_RD_BYTE, S_CHECK, S_FIN
    } state_t;

    typedef enum logic [1:0] {OP_ISSUE, OP_ACK, OP_DONE} op_t;

    // Dallas/Maxim CRC8, data shifted in LSB first.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
            else                c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/ds18b20_reader_crc8_maxim.sv
// Byte-wide Dallas/Maxim CRC8 accumulator; one byte absorbed per enabled cycle.
import ds18b20_reader_pkg::*;

module crc8_maxim (
    input  logic       clk,
    input  logic       RstN,
    input  logic       Clr,
    input  logic       En,
    input  logic [7:0] Byte,
    output logic [7:0] Crc
);

    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN)   Crc <= 8'h00;
        else if (Clr) Crc <= 8'h00;
        else if (En)  Crc <= crc8_byte(Crc, Byte);
    end

endmodule

// File: rtl/ds18b20_reader.sv
// DS18B20 transaction sequencer driving the 1-Wire byte engine.
import ds18b20_reader_pkg::*;

module ds18b20_reader #(
    parameter int unsigned CONV_CYCLES = CONV_CYCLES_DEF,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        RstN,
    input  logic        Start,
    output logic        Busy,
    output logic [15:0] Temp,
    output logic        TempValid,
    output logic        CrcErr,
    output logic        NoDevice,
    output logic        Fault,
    output logic        OwRstN,
    output logic        OwWrite,
    output logic        OwRead,
    output logic [7:0]  OwInData,
    input  logic [7:0]  OwOutData,
    input  logic        OwBusy,
    input  logic        OwPresence
);

    state_t             r_state;
    op_t                r_op;
    logic [ACK_W-1:0]   r_ack_cnt;
    logic [WAIT_W-1:0]  r_wait;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_sp [SP_BYTES];

    logic               w_op_rst;
    logic               w_op_wr;
    logic               w_op_rd;
    logic [7:0]         w_wr_byte;
    logic               w_crc_clr;
    logic               w_crc_en;
    logic [7:0]         w_crc;

    // Decode which engine op the current state performs.
    always_comb begin
        w_op_rst  = (r_state == S_RST1) || (r_state == S_RST2);
        w_op_wr   = 1'b0;
        w_op_rd   = (r_state == S_RD_BYTE);
        w_wr_byte = 8'h00;
        case (r_state)
            S_SKIP1, S_SKIP2: begin w_op_wr = 1'b1; w_wr_byte = CMD_SKIP_ROM; end
            S_CONV:           begin w_op_wr = 1'b1; w_wr_byte = CMD_CONVERT;  end
            S_READ_CMD:       begin w_op_wr = 1'b1; w_wr_byte = CMD_READ_SP;  end
            default:          ;
        endcase
    end

    assign w_crc_clr = (r_state == S_READ_CMD);
    assign w_crc_en  = (r_state == S_RD_BYTE) && (r_op == OP_DONE) && !OwBusy;

    crc8_maxim u_crc (
        .clk  (clk),
        .RstN (RstN),
        .Clr  (w_crc_clr),
        .En   (w_crc_en),
        .Byte (OwOutData),
        .Crc  (w_crc)
    );

    always_ff @(posedge clk or negedge RstN) begin
        if (!RstN) begin
            r_state   <= S_IDLE;
            r_op      <= OP_ISSUE;
            r_ack_cnt <= '0;
            r_wait    <= '0;
            r_idx     <= '0;
            for (int i = 0; i < SP_BYTES; i++) r_sp[i] <= 8'h00;
            Busy      <= 1'b0;
            Temp      <= 16'h0000;
            TempValid <= 1'b0;
            CrcErr    <= 1'b0;
            NoDevice  <= 1'b0;
            Fault     <= 1'b0;
            OwRstN    <= 1'b1;
            OwWrite   <= 1'b0;
            OwRead    <= 1'b0;
            OwInData  <= 8'h00;
        end else begin
            TempValid <= 1'b0;
            OwRstN    <= 1'b1;
            OwWrite   <= 1'b0;
            OwRead    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start && !Busy && !OwBusy) begin
                        CrcErr   <= 1'b0;
                        NoDevice <= 1'b0;
                        Fault    <= 1'b0;
                        Busy     <= 1'b1;
                        r_idx    <= '0;
                        r_wait   <= '0;
                        r_op     <= OP_ISSUE;
                        r_state  <= S_RST1;
                    end
                end
                // Conversion wait: saturating counter, bus left idle.
                S_WAIT_CONV: begin
                    if (r_wait == WAIT_W'(CONV_CYCLES)) begin
                        r_op    <= OP_ISSUE;
                        r_state <= S_RST2;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (w_crc == 8'h00) begin
                        Temp      <= {r_sp[1], r_sp[0]};
                        TempValid <= 1'b1;
                    end else begin
                        CrcErr <= 1'b1;
                    end
                    r_state <= S_FIN;
                end
                S_FIN: begin
                    Busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    case (r_op)
                        OP_ISSUE: begin
                            if (!OwBusy) begin
                                if (w_op_rst) OwRstN <= 1'b0;
                                if (w_op_rd)  OwRead <= 1'b1;
                                if (w_op_wr) begin
                                    OwWrite  <= 1'b1;
                                    OwInData <= w_wr_byte;
                                end
                                r_ack_cnt <= '0;
                                r_op      <= OP_ACK;
                            end
                        end
                        OP_ACK: begin
                            if (OwBusy) begin
                                r_op <= OP_DONE;
                            end else if (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
                                Fault   <= 1'b1;
                                Busy    <= 1'b0;
                                r_op    <= OP_ISSUE;
                                r_state <= S_IDLE;
                            end else begin
                                r_ack_cnt <= r_ack_cnt + 1'b1;
                            end
                        end
                        default: begin
                            // Engine finished: consume its result and advance the sequence.
                            if (!OwBusy) begin
                                r_op <= OP_ISSUE;
                                case (r_state)
                                    S_RST1, S_RST2: begin
                                        if (!OwPresence) begin
                                            NoDevice <= 1'b1;
                                            Busy     <= 1'b0;
                                            r_state  <= S_IDLE;
                                        end else begin
                                            r_state <= (r_state == S_RST1) ? S_SKIP1 : S_SKIP2;
                                        end
                                    end
                                    S_SKIP1:    r_state <= S_CONV;
                                    S_CONV: begin
                                        r_wait  <= '0;
                                        r_state <= S_WAIT_CONV;
                                    end
                                    S_SKIP2:    r_state <= S_READ_CMD;
                                    S_READ_CMD: begin
                                        r_idx   <= '0;
                                        r_state <= S_RD_BYTE;
                                    end
                                    S_RD_BYTE: begin
                                        r_sp[r_idx] <= OwOutData;
                                        if (r_idx == IDX_W'(SP_BYTES - 1)) r_state <= S_CHECK;
                                        else                               r_idx   <= r_idx + 1'b1;
                                    end
                                    default:    r_state <= S_IDLE;
                                endcase
                            end
                        end
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ds18b20_reader.sv
// Bench for ds18b20_reader: behavioural 1-Wire engine + DS18B20 scratchpad slave.
module tb_ds18b20_reader;

    localparam int unsigned CONV = 100;
    localparam int unsigned ACKT = 8;

    logic        clk = 1'b0;
    logic        RstN = 1'b0;
    logic        Start = 1'b0;
    logic        Busy, TempValid, CrcErr, NoDevice, Fault;
    logic [15:0] Temp;
    logic        OwRstN, OwWrite, OwRead;
    logic [7:0]  OwInData;
    logic [7:0]  OwOutData = 8'h00;
    logic        OwBusy = 1'b0;
    logic        OwPresence = 1'b0;

    ds18b20_reader #(.CONV_CYCLES(CONV), .ACK_TIMEOUT(ACKT)) dut (
        .clk(clk), .RstN(RstN), .Start(Start), .Busy(Busy), .Temp(Temp),
        .TempValid(TempValid), .CrcErr(CrcErr), .NoDevice(NoDevice), .Fault(Fault),
        .OwRstN(OwRstN), .OwWrite(OwWrite), .OwRead(OwRead), .OwInData(OwInData),
        .OwOutData(OwOutData), .OwBusy(OwBusy), .OwPresence(OwPresence)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0][7:0] b;
        bit              present;
        int              exp_valid;
        bit              exp_crc;
        bit              exp_nodev;
        logic [15:0]     exp_temp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave + engine model state
    bit              slave_present = 1'b1;
    logic [8:0][7:0] slave_sp = '0;
    bit              eng_ack_off = 1'b0;
    int              eng_phase = 0;
    int              eng_lat = 0;
    int              eng_len = 0;
    int              eng_kind = 0;
    int              rd_ptr = 0;
    int              rst_cnt = 0;
    int              viol_cnt = 0;
    logic [7:0]      wr_log [$];
    logic [15:0]     exp_temp = 16'h0000;

    // Engine runs on the falling edge so it never races the DUT's sampling edge.
    always @(negedge clk) begin
        if (eng_phase != 0 && (!OwRstN || OwWrite || OwRead)) viol_cnt++;
        case (eng_phase)
            0: if (!eng_ack_off && (!OwRstN || OwWrite || OwRead)) begin
                eng_kind = !OwRstN ? 0 : (OwWrite ? 1 : 2);
                if (!OwRstN) rst_cnt++;
                if (OwWrite) wr_log.push_back(OwInData);
                eng_lat   = $urandom_range(0, 2);
                eng_phase = 1;
            end
            1: if (eng_lat == 0) begin
                OwBusy    = 1'b1;
                eng_len   = $urandom_range(2, 6);
                eng_phase = 2;
            end else eng_lat--;
            default: if (eng_len == 0) begin
                if (eng_kind == 0) begin
                    OwPresence = slave_present;
                    rd_ptr     = 0;
                end else if (eng_kind == 2) begin
                    OwOutData = (rd_ptr < 9) ? slave_sp[rd_ptr] : 8'hFF;
                    rd_ptr++;
                end
                OwBusy    = 1'b0;
                eng_phase = 0;
            end else eng_len--;
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference CRC check: plain GF(2) long division of the 72-bit stream by x^8+x^5+x^4+1.
    function automatic bit crc_ok(input logic [8:0][7:0] b);
        logic [8:0] r;
        r = '0;
        for (int i = 0; i < 9; i++)
            for (int k = 0; k < 8; k++) begin
                r = {r[7:0], b[i][k]};
                if (r[8]) r = r ^ 9'h131;
            end
        return r[7:0] == 8'h00;
    endfunction

    function automatic logic [7:0] fix_crc(input logic [8:0][7:0] b);
        logic [8:0][7:0] t;
        t = b;
        for (int c = 0; c < 256; c++) begin
            t[8] = 8'(c);
            if (crc_ok(t)) return 8'(c);
        end
        return 8'h00;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, " Busy"}, Busy, 0);
        chk({tag, " Temp"}, Temp, 0);
        chk({tag, " TempValid"}, TempValid, 0);
        chk({tag, " CrcErr"}, CrcErr, 0);
        chk({tag, " NoDevice"}, NoDevice, 0);
        chk({tag, " Fault"}, Fault, 0);
        chk({tag, " OwRstN"}, OwRstN, 1);
        chk({tag, " OwWrite"}, OwWrite, 0);
        chk({tag, " OwRead"}, OwRead, 0);
        chk({tag, " OwInData"}, OwInData, 0);
    endtask

    task automatic wait_eng_idle();
        int c;
        c = 0;
        while ((OwBusy || eng_phase != 0) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("engine idle wait", c < 200, 1);
    endtask

    task automatic pulse_start();
        @(negedge clk) Start = 1'b1;
        @(negedge clk) Start = 1'b0;
    endtask

    task automatic do_txn(output int vcnt, output bit timed_out);
        vcnt = 0;
        timed_out = 1'b1;
        wait_eng_idle();
        wr_log.delete();
        pulse_start();
        for (int c = 0; c < 4000; c++) begin
            if (TempValid) vcnt++;
            if (!Busy) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int vcnt;
        bit to;
        logic [7:0] exp_wr [4];
        exp_wr = '{8'hCC, 8'h44, 8'hCC, 8'hBE};
        slave_sp      = v.b;
        slave_present = v.present;
        do_txn(vcnt, to);
        chk({tag, " timeout"}, to, 0);
        if (v.exp_valid != 0) exp_temp = v.exp_temp;
        chk({tag, " valid pulses"}, vcnt, v.exp_valid);
        chk({tag, " CrcErr"}, CrcErr, v.exp_crc);
        chk({tag, " NoDevice"}, NoDevice, v.exp_nodev);
        chk({tag, " Fault"}, Fault, 0);
        chk({tag, " Temp"}, Temp, exp_temp);
        if (v.present) begin
            chk({tag, " write count"}, wr_log.size(), 4);
            for (int i = 0; i < 4 && i < wr_log.size(); i++)
                chk($sformatf("%s write %0d", tag, i), wr_log[i], exp_wr[i]);
        end else begin
            chk({tag, " write count"}, wr_log.size(), 0);
        end
    endtask

    vec_t tbl [4];

    initial begin
        int  t0, t1, rst0, vcnt;
        bit  got;
        vec_t rv;

        tbl[0] = '{b: {8'h1C,8'h10,8'h0C,8'hFF,8'h7F,8'h46,8'h4B,8'h05,8'h50}, present: 1,
                   exp_valid: 1, exp_crc: 0, exp_nodev: 0, exp_temp: 16'h0550};
        tbl[1] = '{b: {8'h1D,8'h10,8'h0C,8'hFF,8'h7F,8'h46,8'h4B,8'h05,8'h50}, present: 1,
                   exp_valid: 0, exp_crc: 1, exp_nodev: 0, exp_temp: 16'h0000};
        tbl[2] = '{b: {9{8'hFF}}, present: 1,
                   exp_valid: 0, exp_crc: 1, exp_nodev: 0, exp_temp: 16'h0000};
        tbl[3] = '{b: {8'h1C,8'h10,8'h0C,8'hFF,8'h7F,8'h46,8'h4B,8'h05,8'h50}, present: 0,
                   exp_valid: 0, exp_crc: 0, exp_nodev: 1, exp_temp: 16'h0000};

        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        RstN = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        chk("absent Busy", Busy, 0);

        // Engine never acknowledges: Fault after ACK_TIMEOUT cycles.
        eng_ack_off = 1'b1;
        wait_eng_idle();
        pulse_start();
        t0 = -1; t1 = -1;
        for (int c = 0; c < 100; c++) begin
            if (!OwRstN && t0 < 0) t0 = c;
            if (Fault) begin t1 = c; break; end
            @(negedge clk);
        end
        chk("fault seen", (t0 >= 0) && (t1 >= 0), 1);
        chk("fault latency", t1 - t0, ACKT);
        chk("fault Busy", Busy, 0);
        repeat (5) @(negedge clk);
        chk("fault sticky", Fault, 1);
        eng_ack_off = 1'b0;

        // Start during WAIT_CONV and on the Busy-fall edge must be ignored.
        slave_sp = tbl[0].b;
        slave_present = 1'b1;
        wait_eng_idle();
        wr_log.delete();
        rst0 = rst_cnt;
        pulse_start();
        chk("fault cleared", Fault, 0);
        got = 0;
        for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk);
            got = (wr_log.size() == 2) && (eng_phase == 0);
        end
        chk("reach wait_conv", got, 1);
        repeat (5) @(negedge clk);
        pulse_start();
        got = 0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            got = TempValid;
        end
        chk("t5 TempValid", got, 1);
        Start = 1'b1;
        @(negedge clk) Start = 1'b0;
        chk("t5 Busy fell", Busy, 0);
        repeat (20) @(negedge clk);
        chk("t5 still idle", Busy, 0);
        chk("t5 one transaction", rst_cnt - rst0, 2);
        chk("t5 Temp", Temp, 16'h0550);

        // Reset while reading scratchpad byte 4.
        wait_eng_idle();
        pulse_start();
        got = 0;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            got = (rd_ptr == 4) && (eng_phase != 0);
        end
        chk("reach rd_byte 4", got, 1);
        RstN = 1'b0;
        #1;
        check_reset_vals("midreset");
        exp_temp = 16'h0000;
        repeat (2) @(negedge clk);
        RstN = 1'b1;
        run_vec(tbl[0], "after reset");

        // Randomised scratchpads checked against the reference CRC model.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 9; i++) rv.b[i] = 8'($urandom_range(0, 255));
            if (r % 3 != 2) rv.b[8] = fix_crc(rv.b);
            rv.present   = 1'b1;
            rv.exp_valid = crc_ok(rv.b) ? 1 : 0;
            rv.exp_crc   = !crc_ok(rv.b);
            rv.exp_nodev = 1'b0;
            rv.exp_temp  = {rv.b[1], rv.b[0]};
            run_vec(rv, $sformatf("rand%0d", r));
        end

        chk("no request while engine busy", viol_cnt, 0);
        vcnt = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
